instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address, equal to internal pc.
REQ-006 imem_gnt  input  1  memory accepts request this cycle.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect  input  1  branch/jump taken, from control path.
REQ-010 redirect_pc  input  32  target address.
REQ-011 instr_valid  output  1  decode-side instruction valid.
REQ-012 instr_ready  input  1  decode side consumes instruction.
REQ-013 instr  output  32  held instruction word.
REQ-014 op / funct3 / funct7  output  opcode_e / funct3_e / funct7_e  instr[6:0] / instr[14:12] / instr[31:25], typed per types_pkg.
REQ-015 instr_pc, instr_pc_plus4  output  32 each  address of held instruction and that address +4.
REQ-016 misaligned  output  1  present only when FETCH_ALIGN_CHECK_EN is defined.

Function
REQ-017 FSM SHALL have states IDLE, REQ, WAIT, VALID.
REQ-018 IDLE: all outputs low; next state REQ unconditionally.
REQ-019 REQ: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT, else remain REQ.
REQ-020 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into instr, pc into instr_pc -> VALID.
REQ-021 VALID: instr_valid=1; on instr_ready -> pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), state REQ.
REQ-022 Minimum latency SHALL be 2 cycles from granted request to instr_valid; back-to-back throughput one instruction per 3 cycles.
REQ-023 instr, instr_pc, derived fields SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 redirect in REQ or VALID: pc<=redirect_pc, instr_valid deasserted next cycle, state REQ; redirect SHALL take priority over instr_ready and imem_gnt in the same cycle (the granted request is treated as outstanding, see REQ-025).
REQ-025 redirect in WAIT, or with a grant in the same cycle: pc<=redirect_pc, discard flag set; the next imem_rvalid SHALL be dropped (not presented), discard cleared, state REQ.
REQ-026 redirect coincident with imem_rvalid in WAIT: data dropped, state REQ, discard not set.
REQ-027 Second redirect before the outstanding response returns SHALL overwrite pc; only one response is discarded.
REQ-028 redirect in IDLE SHALL load pc; IDLE still proceeds to REQ.
REQ-029 At most one memory request SHALL be outstanding.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, pc=RESET_PC, instr=0, instr_pc=0, discard=0, imem_req=0, instr_valid=0, misaligned=0.
REQ-031 Reset mid-WAIT SHALL abandon the transaction; a late imem_rvalid after release SHALL be ignored outside WAIT.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL be ignored (pc, state unchanged) and misaligned pulses high one cycle.
REQ-033 Macro undefined: misaligned port absent; redirect_pc[1:0] forced to 2'b00 when loaded.

Verification
REQ-034 Reset release, gnt and rvalid tied 1, ready 1 -> imem_addr 0x0, 0x4, 0x8 in successive REQ cycles; instr_valid every third cycle.
REQ-035 instr_ready held 0 for 5 cycles in VALID -> instr, instr_pc unchanged; no imem_req.
REQ-036 redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word dropped; next imem_addr 0x100.
REQ-037 redirect to 0x200 same cycle as instr_ready in VALID -> pc 0x200, no 0x+4 fetch.
REQ-038 pc at 0xFFFF_FFFC consumed -> next imem_addr 0x0.
REQ-039 With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> misaligned 1 cycle, pc unchanged; without, fetch at 0x100.

Source files
------------

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - instruction field encodings shared by the fetch unit and its consumers
package types_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    F3_0 = 3'd0, F3_1 = 3'd1, F3_2 = 3'd2, F3_3 = 3'd3,
    F3_4 = 3'd4, F3_5 = 3'd5, F3_6 = 3'd6, F3_7 = 3'd7
  } funct3_e;

  typedef enum logic [6:0] {
    F7_BASE   = 7'h00,
    F7_MULDIV = 7'h01,
    F7_ALT    = 7'h20
  } funct7_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch FSM with redirect/discard handling
// Optional FETCH_ALIGN_CHECK_EN: ignore misaligned redirects and pulse misaligned.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output types_pkg::opcode_e op,
  output types_pkg::funct3_e funct3,
  output types_pkg::funct7_e funct7,
  output logic [31:0]        instr_pc,
  output logic [31:0]        instr_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_instr_pc, w_instr_pc_next;
  logic        r_discard, w_discard_next;
  logic        w_redir;
  logic [31:0] w_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic w_bad_align;
  logic r_misaligned;

  assign w_bad_align = redirect & (redirect_pc[1:0] != 2'b00);
  assign w_redir     = redirect & ~w_bad_align;
  assign w_target    = redirect_pc;
  assign misaligned  = r_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misaligned <= 1'b0;
    else        r_misaligned <= w_bad_align;
  end
`else
  assign w_redir  = redirect;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_discard_next  = r_discard;
    imem_req        = 1'b0;
    instr_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_redir) w_pc_next = w_target;
        w_state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (w_redir) w_pc_next = w_target;
        if (imem_gnt) begin
          // A grant alongside a redirect is still outstanding; mark it for discard.
          if (w_redir) w_discard_next = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (w_redir) w_pc_next = w_target;
        if (imem_rvalid) begin
          if (r_discard || w_redir) begin
            w_discard_next = 1'b0;
            w_state_next   = REQ;
          end else begin
            w_instr_next    = imem_rdata;
            w_instr_pc_next = r_pc;
            w_state_next    = VALID;
          end
        end else if (w_redir) begin
          w_discard_next = 1'b1;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (w_redir) begin
          w_pc_next    = w_target;
          w_state_next = REQ;
        end else if (instr_ready) begin
          w_pc_next    = r_pc + 32'd4;
          w_state_next = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_discard  <= w_discard_next;
    end
  end

  assign imem_addr      = r_pc;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc + 32'd4;
  assign op             = types_pkg::opcode_e'(r_instr[6:0]);
  assign funct3         = types_pkg::funct3_e'(r_instr[14:12]);
  assign funct7         = types_pkg::funct7_e'(r_instr[31:25]);

endmodule
